// File: rtl/alu_definitions_pkg.sv
// Shared ALU encodings, operand selects and the ID/EX bundle.
// Imported by the execute-stage operand logic.
package alu_definitions;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_ctrl_t;

  typedef enum logic [1:0] {
    OP1_RS1  = 2'd0,
    OP1_PC   = 2'd1,
    OP1_ZERO = 2'd2
  } op1_sel_t;

  typedef enum logic [1:0] {
    OP2_RS2  = 2'd0,
    OP2_IMM  = 2'd1,
    OP2_FOUR = 2'd2
  } op2_sel_t;

  typedef struct packed {
    logic                  valid;
    logic [XLEN-1:0]       pc;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [XLEN-1:0]       rs1_data;
    logic [XLEN-1:0]       rs2_data;
    logic [XLEN-1:0]       imm;
    op1_sel_t              op1_sel;
    op2_sel_t              op2_sel;
    alu_ctrl_t             alu_ctrl;
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_write;
    logic                  is_load;
  } id_ex_t;

endpackage

// File: rtl/ex_operand_stage_fwd_mux.sv
// One source operand: picks the newest in-flight value for a register.
// EX/MEM beats MEM/WB; x0 always reads as zero.
module fwd_mux
  import alu_definitions::*;
(
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic [XLEN-1:0]       data,
  input  logic [REG_ADDR_W-1:0] exmem_rd,
  input  logic                  exmem_we,
  input  logic [XLEN-1:0]       exmem_result,
  input  logic [REG_ADDR_W-1:0] memwb_rd,
  input  logic                  memwb_we,
  input  logic [XLEN-1:0]       memwb_result,
  output logic [XLEN-1:0]       value
);

  logic exmem_hit;
  logic memwb_hit;

  assign exmem_hit = exmem_we && (exmem_rd == rs);
  assign memwb_hit = memwb_we && (memwb_rd == rs);

  always_comb begin
    value = data;
    if (rs == '0)
      value = '0;
    else if (exmem_hit)
      value = exmem_result;
    else if (memwb_hit)
      value = memwb_result;
  end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX register with per-operand forwarding, ALU operand select
// and load-use hazard detection.
module ex_operand_stage
  import alu_definitions::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [XLEN-1:0]       id_pc,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [XLEN-1:0]       id_rs1_data,
  input  logic [XLEN-1:0]       id_rs2_data,
  input  logic [XLEN-1:0]       id_imm,
  input  op1_sel_t              id_op1_sel,
  input  op2_sel_t              id_op2_sel,
  input  alu_ctrl_t             id_alu_ctrl,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_is_load,
  input  logic [REG_ADDR_W-1:0] exmem_rd,
  input  logic                  exmem_we,
  input  logic [XLEN-1:0]       exmem_result,
  input  logic [REG_ADDR_W-1:0] memwb_rd,
  input  logic                  memwb_we,
  input  logic [XLEN-1:0]       memwb_result,
  input  logic                  stall,
  input  logic                  flush,
  output logic [XLEN-1:0]       alu_op1,
  output logic [XLEN-1:0]       alu_op2,
  output alu_ctrl_t             alu_ctrl,
  output logic                  ex_valid,
  output logic [XLEN-1:0]       ex_pc,
  output logic [XLEN-1:0]       ex_store_data,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic                  ex_reg_write,
  output logic                  ex_is_load,
  output logic                  load_use_stall
);

  id_ex_t          ex_q;
  id_ex_t          id_d;
  logic [XLEN-1:0] fwd_rs1;
  logic [XLEN-1:0] fwd_rs2;
  logic            rs1_hit;
  logic            rs2_hit;

  // An empty decode slot enters EX as a clean bubble.
  always_comb begin
    id_d           = '0;
    id_d.valid     = id_valid;
    id_d.pc        = id_pc;
    id_d.rs1       = id_rs1;
    id_d.rs2       = id_rs2;
    id_d.rs1_data  = id_rs1_data;
    id_d.rs2_data  = id_rs2_data;
    id_d.imm       = id_imm;
    id_d.op1_sel   = id_op1_sel;
    id_d.op2_sel   = id_op2_sel;
    id_d.alu_ctrl  = id_alu_ctrl;
    id_d.rd        = id_valid ? id_rd : '0;
    id_d.reg_write = id_valid & id_reg_write;
    id_d.is_load   = id_valid & id_is_load;
  end

  fwd_mux u_fwd_rs1 (
    .rs           (ex_q.rs1),
    .data         (ex_q.rs1_data),
    .exmem_rd     (exmem_rd),
    .exmem_we     (exmem_we),
    .exmem_result (exmem_result),
    .memwb_rd     (memwb_rd),
    .memwb_we     (memwb_we),
    .memwb_result (memwb_result),
    .value        (fwd_rs1)
  );

  fwd_mux u_fwd_rs2 (
    .rs           (ex_q.rs2),
    .data         (ex_q.rs2_data),
    .exmem_rd     (exmem_rd),
    .exmem_we     (exmem_we),
    .exmem_result (exmem_result),
    .memwb_rd     (memwb_rd),
    .memwb_we     (memwb_we),
    .memwb_result (memwb_result),
    .value        (fwd_rs2)
  );

  assign rs1_hit = id_use_rs1 && (id_rs1 == ex_q.rd);
  assign rs2_hit = id_use_rs2 && (id_rs2 == ex_q.rd);

  assign load_use_stall = ex_q.valid && ex_q.is_load
                       && (ex_q.rd != '0) && id_valid
                       && (rs1_hit || rs2_hit) && !flush;

  // Stall refreshes the operands so a producer retiring meanwhile is kept.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q <= '0;
    end else if (flush) begin
      ex_q <= '0;
    end else if (stall) begin
      ex_q.rs1_data <= fwd_rs1;
      ex_q.rs2_data <= fwd_rs2;
    end else if (load_use_stall) begin
      ex_q <= '0;
    end else begin
      ex_q <= id_d;
    end
  end

  always_comb begin
    alu_op1 = '0;
    unique case (1'b1)
      ex_q.op1_sel == OP1_RS1:  alu_op1 = fwd_rs1;
      ex_q.op1_sel == OP1_PC:   alu_op1 = ex_q.pc;
      ex_q.op1_sel == OP1_ZERO: alu_op1 = '0;
      default:                  alu_op1 = '0;
    endcase
  end

  always_comb begin
    alu_op2 = '0;
    unique case (1'b1)
      ex_q.op2_sel == OP2_RS2:  alu_op2 = fwd_rs2;
      ex_q.op2_sel == OP2_IMM:  alu_op2 = ex_q.imm;
      ex_q.op2_sel == OP2_FOUR: alu_op2 = XLEN'(4);
      default:                  alu_op2 = '0;
    endcase
  end

  assign alu_ctrl      = ex_q.alu_ctrl;
  assign ex_valid      = ex_q.valid;
  assign ex_pc         = ex_q.pc;
  assign ex_store_data = fwd_rs2;
  assign ex_rd         = ex_q.rd;
  assign ex_reg_write  = ex_q.reg_write;
  assign ex_is_load    = ex_q.is_load;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Scoreboard bench for ex_operand_stage: stimulus queues expectations,
// a negedge monitor pops and compares them on their due cycle.
module tb_ex_operand_stage;
  import alu_definitions::*;

  logic            clk = 1'b0;
  logic            rst;
  logic            id_valid;
  logic [31:0]     id_pc;
  logic [4:0]      id_rs1, id_rs2;
  logic            id_use_rs1, id_use_rs2;
  logic [31:0]     id_rs1_data, id_rs2_data, id_imm;
  op1_sel_t        id_op1_sel;
  op2_sel_t        id_op2_sel;
  alu_ctrl_t       id_alu_ctrl;
  logic [4:0]      id_rd;
  logic            id_reg_write, id_is_load;
  logic [4:0]      exmem_rd, memwb_rd;
  logic            exmem_we, memwb_we;
  logic [31:0]     exmem_result, memwb_result;
  logic            stall, flush;
  logic [31:0]     alu_op1, alu_op2, ex_pc, ex_store_data;
  alu_ctrl_t       alu_ctrl;
  logic            ex_valid, ex_reg_write, ex_is_load;
  logic [4:0]      ex_rd;
  logic            load_use_stall;

  ex_operand_stage dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_imm(id_imm), .id_op1_sel(id_op1_sel), .id_op2_sel(id_op2_sel),
    .id_alu_ctrl(id_alu_ctrl), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_is_load(id_is_load),
    .exmem_rd(exmem_rd), .exmem_we(exmem_we), .exmem_result(exmem_result),
    .memwb_rd(memwb_rd), .memwb_we(memwb_we), .memwb_result(memwb_result),
    .stall(stall), .flush(flush),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_ctrl(alu_ctrl),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_store_data(ex_store_data),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_is_load(ex_is_load),
    .load_use_stall(load_use_stall)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] M_OP1 = 7'h01;
  localparam logic [6:0] M_OP2 = 7'h02;
  localparam logic [6:0] M_VLD = 7'h04;
  localparam logic [6:0] M_RW  = 7'h08;
  localparam logic [6:0] M_LUS = 7'h10;
  localparam logic [6:0] M_CTL = 7'h20;
  localparam logic [6:0] M_ST  = 7'h40;

  typedef struct {
    int          due;
    string       name;
    logic [6:0]  mask;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] st;
    logic        vld;
    logic        rw;
    logic        lus;
    logic [3:0]  ctl;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, string f,
                              logic [31:0] act, logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s.%s: got %h want %h", nm, f, act, req);
    end
  endfunction

  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      if (e.due < cyc) begin
        n_vec++;
        n_bad++;
        $display("FAIL %s: missed due cycle %0d (now %0d)",
                 e.name, e.due, cyc);
      end else begin
        if (e.mask & M_OP1) chk(e.name, "op1", alu_op1, e.op1);
        if (e.mask & M_OP2) chk(e.name, "op2", alu_op2, e.op2);
        if (e.mask & M_ST)  chk(e.name, "st", ex_store_data, e.st);
        if (e.mask & M_VLD) chk(e.name, "valid", 32'(ex_valid), 32'(e.vld));
        if (e.mask & M_RW)  chk(e.name, "rw", 32'(ex_reg_write), 32'(e.rw));
        if (e.mask & M_LUS) chk(e.name, "lus", 32'(load_use_stall), 32'(e.lus));
        if (e.mask & M_CTL) chk(e.name, "ctrl", 32'(alu_ctrl), 32'(e.ctl));
      end
    end
  end

  task automatic push(string nm, int due, logic [6:0] m,
                      logic [31:0] op1, logic [31:0] op2, logic [31:0] st,
                      logic vld, logic rw, logic lus, logic [3:0] ctl);
    exp_t e;
    e.due = due; e.name = nm; e.mask = m;
    e.op1 = op1; e.op2 = op2; e.st = st;
    e.vld = vld; e.rw = rw; e.lus = lus; e.ctl = ctl;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic id_set(logic v, logic [4:0] rs1, logic [4:0] rs2,
                        logic [4:0] rd, logic u1, logic u2,
                        logic [31:0] d1, logic [31:0] d2,
                        logic rw, logic ld);
    id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_use_rs1 = u1; id_use_rs2 = u2;
    id_rs1_data = d1; id_rs2_data = d2;
    id_reg_write = rw; id_is_load = ld;
  endtask

  task automatic sel_set(op1_sel_t a, op2_sel_t b, alu_ctrl_t c,
                         logic [31:0] pc, logic [31:0] imm);
    id_op1_sel = a; id_op2_sel = b; id_alu_ctrl = c;
    id_pc = pc; id_imm = imm;
  endtask

  task automatic wb_clear();
    exmem_rd = '0; exmem_we = 1'b0; exmem_result = '0;
    memwb_rd = '0; memwb_we = 1'b0; memwb_result = '0;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    id_set(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    sel_set(OP1_RS1, OP2_RS2, ALU_ADD, 0, 0);
    wb_clear();
    tick(); tick();
    push("reset", cyc, M_OP1|M_OP2|M_VLD|M_RW|M_CTL|M_LUS,
         0, 0, 0, 0, 0, 0, 4'd0);
    rst = 1'b0;
    tick();

    // add x3 = x1 + x2, no hazard
    id_set(1, 5'd1, 5'd2, 5'd3, 1, 1, 32'd5, 32'd7, 1, 0);
    push("no_hazard", cyc + 1, M_OP1|M_OP2|M_VLD|M_RW,
         32'd5, 32'd7, 0, 1, 1, 0, 4'd0);
    tick();

    // forwarding priority, same instruction reloaded twice
    id_set(1, 5'd1, 5'd2, 5'd4, 1, 1, 32'h11, 32'h22, 1, 0);
    tick();
    exmem_rd = 5'd1; exmem_we = 1'b1; exmem_result = 32'hAA;
    memwb_rd = 5'd1; memwb_we = 1'b1; memwb_result = 32'hBB;
    push("fwd_exmem", cyc, M_OP1|M_OP2, 32'hAA, 32'h22, 0, 0, 0, 0, 4'd0);
    tick();
    exmem_we = 1'b0;
    push("fwd_memwb", cyc, M_OP1|M_OP2, 32'hBB, 32'h22, 0, 0, 0, 0, 4'd0);

    // x0 never forwarded; store data still follows rs2
    id_set(1, 5'd0, 5'd2, 5'd6, 1, 1, 32'h0, 32'h22, 1, 0);
    sel_set(OP1_RS1, OP2_IMM, ALU_ADD, 0, 32'h100);
    tick();
    wb_clear();
    exmem_rd = 5'd0; exmem_we = 1'b1; exmem_result = 32'hFF;
    push("x0", cyc, M_OP1|M_OP2|M_ST, 32'h0, 32'h100, 32'h22, 0, 0, 0, 4'd0);

    // PC / FOUR selects
    id_set(1, 5'd1, 5'd2, 5'd1, 1, 1, 32'h9, 32'h9, 1, 0);
    sel_set(OP1_PC, OP2_FOUR, ALU_ADD, 32'h80, 0);
    push("pc_four", cyc + 1, M_OP1|M_OP2, 32'h80, 32'd4, 0, 0, 0, 0, 4'd0);
    tick();
    wb_clear();

    // invalid select encodings read as zero
    id_set(1, 5'd1, 5'd2, 5'd1, 1, 1, 32'd5, 32'd7, 1, 0);
    sel_set(op1_sel_t'(2'd3), op2_sel_t'(2'd3), ALU_OR, 0, 32'h55);
    push("bad_sel", cyc + 1, M_OP1|M_OP2|M_VLD|M_CTL,
         0, 0, 0, 1, 0, 0, 4'd8);
    tick();

    // load-use: lw x5 then add reading x5
    id_set(1, 5'd1, 5'd0, 5'd5, 1, 0, 32'h1000, 0, 1, 1);
    sel_set(OP1_RS1, OP2_IMM, ALU_ADD, 0, 32'h4);
    tick();
    id_set(1, 5'd5, 5'd6, 5'd7, 1, 1, 0, 0, 1, 0);
    sel_set(OP1_RS1, OP2_RS2, ALU_ADD, 0, 0);
    push("lu_detect", cyc, M_LUS|M_VLD, 0, 0, 0, 1, 0, 1, 4'd0);
    tick();
    push("lu_bubble", cyc, M_VLD|M_RW|M_LUS, 0, 0, 0, 0, 0, 0, 4'd0);
    id_set(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();

    // stall while a MEM/WB producer retires for one cycle only
    id_set(1, 5'd1, 5'd2, 5'd8, 1, 1, 32'h9, 32'h55, 1, 0);
    tick();
    id_set(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    stall = 1'b1;
    memwb_rd = 5'd2; memwb_we = 1'b1; memwb_result = 32'h1234;
    push("stall_c1", cyc, M_OP2|M_VLD, 0, 32'h1234, 0, 1, 0, 0, 4'd0);
    tick();
    memwb_we = 1'b0;
    push("stall_c2", cyc, M_OP2|M_VLD, 0, 32'h1234, 0, 1, 0, 0, 4'd0);
    tick();
    push("stall_c3", cyc, M_OP2|M_OP1, 32'h9, 32'h1234, 0, 0, 0, 0, 4'd0);
    tick();
    stall = 1'b0;
    push("stall_rel", cyc, M_OP2|M_VLD, 0, 32'h1234, 0, 1, 0, 0, 4'd0);
    tick();

    // flush+stall with a load-use pair present
    wb_clear();
    id_set(1, 5'd1, 5'd0, 5'd5, 1, 0, 32'h10, 0, 1, 1);
    tick();
    id_set(1, 5'd5, 5'd0, 5'd9, 1, 0, 0, 0, 1, 0);
    stall = 1'b1; flush = 1'b1;
    push("flush_lus", cyc, M_LUS|M_VLD, 0, 0, 0, 1, 0, 0, 4'd0);
    push("flush_stall", cyc + 1, M_VLD|M_RW, 0, 0, 0, 0, 0, 0, 4'd0);
    tick();
    stall = 1'b0; flush = 1'b0;

    // reset while stalled
    id_set(1, 5'd1, 5'd2, 5'd3, 1, 1, 32'h77, 32'h88, 1, 0);
    sel_set(OP1_PC, OP2_IMM, ALU_SUB, 32'h40, 32'h8);
    tick();
    id_set(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    stall = 1'b1;
    push("pre_rst", cyc, M_OP1|M_OP2|M_CTL|M_VLD,
         32'h40, 32'h8, 0, 1, 0, 0, 4'd1);
    tick();
    rst = 1'b1;
    push("rst_stall", cyc + 1, M_OP1|M_OP2|M_VLD|M_RW|M_CTL,
         0, 0, 0, 0, 0, 0, 4'd0);
    tick();
    rst = 1'b0; stall = 1'b0;

    for (int i = 0; i < 10 && sb.size() > 0; i++) tick();
    if (sb.size() > 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
